// File: rtl/clb_cfg_loader.sv
// Serial configuration loader: hunts PRE, shifts NCLB frames into a shadow, then commits atomically.
// Define CLB_CFG_PARITY_EN to add a trailing even-parity bit per frame; the default build has no parity.
module clb_cfg_loader #(
  parameter int          NCLB  = 4,
  parameter int          CFG_W = 37,
  parameter logic [7:0]  PRE   = 8'b1111_0010
) (
  input  logic                  K,
  input  logic                  RSTN,
  input  logic                  DIN,
  input  logic                  DIN_VLD,
  output logic [NCLB*CFG_W-1:0] CFG_BUS,
  output logic                  CFG_VALID,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int FW = (NCLB > 1) ? $clog2(NCLB) : 1;
  localparam int BW = $clog2(CFG_W);
  localparam logic [FW-1:0]    LAST_FRAME = FW'(NCLB - 1);
  localparam logic [BW-1:0]    LAST_BIT   = BW'(CFG_W - 1);
  localparam logic [CFG_W-1:0] DEF_SLICE  = CFG_W'(37'h0AB545403E);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_COMMIT
`ifdef CLB_CFG_PARITY_EN
    , S_PAR
`endif
  } state_t;

  state_t                  r_state, w_state_nxt;
  // Only the last 7 stream bits are kept; the incoming bit completes the 8-bit window.
  logic [6:0]              r_hunt;
  logic [NCLB*CFG_W-1:0]   r_shadow;
  logic [NCLB*CFG_W-1:0]   r_cfg_bus;
  logic [FW-1:0]           r_frame;
  logic [BW-1:0]           r_bit;
  logic                    r_cfg_valid, r_busy, r_done;
  logic [7:0]              w_hunt_nxt;
  logic                    w_detect, w_shift, w_frame_adv, w_par_fail, w_commit;

`ifdef CLB_CFG_PARITY_EN
  logic                    r_err;
  logic                    w_par_odd;

  always_comb begin
    w_par_odd = DIN;
    for (int f = 0; f < NCLB; f++)
      if (r_frame == FW'(f)) w_par_odd = DIN ^ (^r_shadow[f*CFG_W +: CFG_W]);
  end
`endif

  always_ff @(posedge K) begin
    if (!RSTN) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hunt_nxt  = {r_hunt, DIN};
    w_detect    = 1'b0;
    w_shift     = 1'b0;
    w_frame_adv = 1'b0;
    w_par_fail  = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (DIN_VLD && (w_hunt_nxt == PRE)) begin
          w_detect    = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (DIN_VLD) begin
          w_shift = 1'b1;
          if (r_bit == LAST_BIT) begin
`ifdef CLB_CFG_PARITY_EN
            w_state_nxt = S_PAR;
`else
            if (r_frame == LAST_FRAME) w_state_nxt = S_COMMIT;
            else                       w_frame_adv = 1'b1;
`endif
          end
        end
      end
`ifdef CLB_CFG_PARITY_EN
      S_PAR: begin
        if (DIN_VLD) begin
          if (w_par_odd) begin
            w_par_fail  = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (r_frame == LAST_FRAME) begin
            w_state_nxt = S_COMMIT;
          end else begin
            w_frame_adv = 1'b1;
            w_state_nxt = S_DATA;
          end
        end
      end
`endif
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge K) begin
    if (!RSTN) begin
      r_hunt      <= '0;
      r_shadow    <= '0;
      r_frame     <= '0;
      r_bit       <= '0;
      r_cfg_bus   <= {NCLB{DEF_SLICE}};
      r_cfg_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef CLB_CFG_PARITY_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_cfg_valid <= w_commit;
      if (r_state == S_IDLE && DIN_VLD) r_hunt <= w_hunt_nxt[6:0];
      if (w_detect) begin
        // Clearing the window stops stale preamble bits from re-triggering after this load.
        r_hunt  <= '0;
        r_frame <= '0;
        r_bit   <= '0;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
`ifdef CLB_CFG_PARITY_EN
        r_err   <= 1'b0;
`endif
      end
      if (w_shift) begin
        for (int f = 0; f < NCLB; f++)
          if (r_frame == FW'(f))
            r_shadow[f*CFG_W +: CFG_W] <= {r_shadow[f*CFG_W +: CFG_W-1], DIN};
        r_bit <= (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
      end
      if (w_frame_adv) r_frame <= r_frame + 1'b1;
`ifdef CLB_CFG_PARITY_EN
      if (w_par_fail) begin
        r_err    <= 1'b1;
        r_busy   <= 1'b0;
        r_shadow <= '0;
        r_hunt   <= '0;
      end
`endif
      if (w_commit) begin
        r_cfg_bus <= r_shadow;
        r_done    <= 1'b1;
        r_busy    <= 1'b0;
      end
    end
  end

  assign CFG_BUS   = r_cfg_bus;
  assign CFG_VALID = r_cfg_valid;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
`ifdef CLB_CFG_PARITY_EN
  assign ERR       = r_err;
`else
  assign ERR       = 1'b0;
`endif

endmodule
